// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits 32-bit loads/stores into two 16-bit async SRAM phases and freezes the pipeline meanwhile.
// Optional last-load buffer enabled with `define LAST_READ_BUF_EN.
module mem_stage_sram_ctrl #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned SRAM_WAIT = 1,
    parameter int unsigned SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_value,
    output logic               ready,
    output logic [31:0]        MEM_read_value,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    localparam int unsigned WA_W = SRAM_AW - 1;
    localparam int unsigned PH_W = 3;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SRAM_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic [WA_W-1:0]   r_wa;
    logic [31:0]       r_st_value;
    logic              r_is_store;
    logic [15:0]       r_rd_lo;
    logic [31:0]       r_mem_read_value;

    logic              w_req;
    logic [WA_W-1:0]   w_wa_in;
    logic              w_buf_hit;
    logic              w_drive;
    logic              w_phase_end;

    assign w_req       = MEM_R_EN | MEM_W_EN;
    // Word address with 32-bit wrap; bits above the SRAM range are dropped.
    assign w_wa_in     = WA_W'((ALU_result - 32'(ADDR_BASE)) >> 2);
    assign w_phase_end = (r_phase == PH_LAST);

`ifdef LAST_READ_BUF_EN
    logic              r_buf_valid;
    logic [WA_W-1:0]   r_buf_wa;
    logic [31:0]       r_buf_data;

    assign w_buf_hit = MEM_R_EN & ~MEM_W_EN & r_buf_valid & (r_buf_wa == w_wa_in);

    // Last completed load; invalidated by a store to the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_wa    <= '0;
            r_buf_data  <= '0;
        end else begin
            if (r_state == S_IDLE && MEM_W_EN && r_buf_valid && (r_buf_wa == w_wa_in)) begin
                r_buf_valid <= 1'b0;
            end
            if (r_state == S_HI && w_phase_end && !r_is_store) begin
                r_buf_valid <= 1'b1;
                r_buf_wa    <= r_wa;
                r_buf_data  <= {SRAM_DQ, r_rd_lo};
            end
        end
    end
`else
    assign w_buf_hit = 1'b0;
`endif

    // Next state, phase counter and pipeline freeze.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready       = ~w_req;
                w_phase_nxt = '0;
                if (w_req) begin
                    w_state_nxt = w_buf_hit ? S_DONE : S_LO;
                end
            end
            S_LO: begin
                if (w_phase_end) begin
                    w_state_nxt = S_HI;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            S_HI: begin
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            S_DONE: begin
                ready       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_phase          <= '0;
            r_wa             <= '0;
            r_st_value       <= '0;
            r_is_store       <= 1'b0;
            r_rd_lo          <= '0;
            r_mem_read_value <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            if (r_state == S_IDLE && w_req) begin
                r_wa       <= w_wa_in;
                r_st_value <= ST_value;
                r_is_store <= MEM_W_EN;
            end
            if (r_state == S_LO && w_phase_end && !r_is_store) begin
                r_rd_lo <= SRAM_DQ;
            end
            if (r_state == S_HI && w_phase_end && !r_is_store) begin
                r_mem_read_value <= {SRAM_DQ, r_rd_lo};
            end
`ifdef LAST_READ_BUF_EN
            if (r_state == S_IDLE && w_buf_hit) begin
                r_mem_read_value <= r_buf_data;
            end
`endif
        end
    end

    // SRAM pins decode only from state and captured registers.
    assign w_drive        = r_is_store & ((r_state == S_LO) | (r_state == S_HI));
    assign SRAM_WE_N      = ~w_drive;
    assign SRAM_ADDR      = {r_wa, (r_state == S_HI)};
    assign SRAM_DQ        = w_drive ? ((r_state == S_HI) ? r_st_value[31:16] : r_st_value[15:0])
                                    : 16'hzzzz;
    assign MEM_read_value = r_mem_read_value;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: two instances (SRAM_WAIT 1 and 3), async SRAM models, word-level reference memory.
module tb_mem_stage_sram_ctrl;

`ifdef LAST_READ_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif
    localparam int unsigned AW = 18;

    logic        clk;
    logic        rst;
    logic        r_en  [2];
    logic        w_en  [2];
    logic [31:0] alu   [2];
    logic [31:0] st    [2];
    logic        rdy   [2];
    logic [31:0] rval  [2];
    logic [AW-1:0] saddr [2];
    logic        we_n  [2];
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    logic [15:0] sram0 [0:(1<<AW)-1];
    logic [15:0] sram1 [0:(1<<AW)-1];

    int          n_checks;
    int          n_pass;
    int          wait_of [2];
    logic [AW-1:0] addr_log [64];

    logic [31:0] ref_mem [int];
    logic [31:0] last_load [2];
    bit          buf_valid [2];
    int          buf_wa    [2];

    mem_stage_sram_ctrl #(.ADDR_BASE(1024), .SRAM_WAIT(1), .SRAM_AW(AW)) u_dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
        .ALU_result(alu[0]), .ST_value(st[0]), .ready(rdy[0]), .MEM_read_value(rval[0]),
        .SRAM_DQ(dq0), .SRAM_ADDR(saddr[0]), .SRAM_WE_N(we_n[0])
    );

    mem_stage_sram_ctrl #(.ADDR_BASE(1024), .SRAM_WAIT(3), .SRAM_AW(AW)) u_dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
        .ALU_result(alu[1]), .ST_value(st[1]), .ready(rdy[1]), .MEM_read_value(rval[1]),
        .SRAM_DQ(dq1), .SRAM_ADDR(saddr[1]), .SRAM_WE_N(we_n[1])
    );

    // Asynchronous SRAM models: read drives the bus whenever WE_N is high.
    assign dq0 = we_n[0] ? sram0[saddr[0]] : 16'hzzzz;
    assign dq1 = we_n[1] ? sram1[saddr[1]] : 16'hzzzz;

    always @(posedge clk) begin
        if (we_n[0] === 1'b0) sram0[saddr[0]] <= dq0;
        if (we_n[1] === 1'b0) sram1[saddr[1]] <= dq1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic int wa_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] ref_rd(input int d, input int wa);
        int key;
        key = d * (1 << 20) + wa;
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    function automatic logic [15:0] sram_rd(input int d, input logic [AW-1:0] a);
        return (d == 0) ? sram0[a] : sram1[a];
    endfunction

    function automatic logic [15:0] dq_of(input int d);
        return (d == 0) ? dq0 : dq1;
    endfunction

    // Higher-level model: what a completed access means for memory, buffer and read value.
    task automatic model_update(input int d, input bit is_store, input logic [31:0] a, input logic [31:0] v);
        int wa;
        wa = wa_of(a);
        if (is_store) begin
            ref_mem[d * (1 << 20) + wa] = v;
            if (buf_valid[d] && buf_wa[d] == wa) buf_valid[d] = 1'b0;
        end else begin
            last_load[d] = ref_rd(d, wa);
            buf_valid[d] = 1'b1;
            buf_wa[d]    = wa;
        end
    endtask

    function automatic int exp_low(input int d, input bit is_store, input logic [31:0] a);
        if (BUF_EN && !is_store && buf_valid[d] && buf_wa[d] == wa_of(a)) return 1;
        return 1 + 2 * wait_of[d];
    endfunction

    // Entered at a falling edge; returns at the falling edge after DONE with request dropped.
    task automatic access(input int d, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] v, output int low, output int we_cyc,
                          output int dq_err, output logic [31:0] rv);
        r_en[d] = rd; w_en[d] = wr; alu[d] = a; st[d] = v;
        #1;
        low = 0; we_cyc = 0; dq_err = 0;
        while (rdy[d] === 1'b0 && low < 64) begin
            addr_log[low] = saddr[d];
            if (we_n[d] === 1'b0) we_cyc++;
            if (!wr && low > 0 && dq_of(d) !== sram_rd(d, saddr[d])) dq_err++;
            low++;
            @(negedge clk); #1;
        end
        rv = rval[d];
        @(negedge clk);
        r_en[d] = 1'b0; w_en[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            r_en[d] = 1'b0; w_en[d] = 1'b0; alu[d] = '0; st[d] = '0;
            last_load[d] = '0; buf_valid[d] = 1'b0; buf_wa[d] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (rdy[0] !== 1'b1) $display("FAIL reset_ready_in_rst got=%b exp=1", rdy[0]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rdy[d] !== 1'b1 || we_n[d] !== 1'b1 || rval[d] !== 32'h0 || saddr[d] !== '0)
                $display("FAIL reset_values dut%0d ready=%b we_n=%b rv=%h addr=%h exp 1/1/0/0",
                         d, rdy[d], we_n[d], rval[d], saddr[d]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int low, we_cyc, dq_err;
        logic [31:0] rv;
        access(0, 1'b1, 1'b0, 32'h404, 32'hDEADBEEF, low, we_cyc, dq_err, rv);
        model_update(0, 1'b1, 32'h404, 32'hDEADBEEF);
        n_checks++;
        if (low !== 3 || we_cyc !== 2) $display("FAIL store_timing low=%0d we=%0d exp 3/2", low, we_cyc);
        else n_pass++;
        n_checks++;
        if (addr_log[1] !== 18'd2 || addr_log[2] !== 18'd3)
            $display("FAIL store_addr got=%0d,%0d exp 2,3", addr_log[1], addr_log[2]);
        else n_pass++;
        n_checks++;
        if (sram0[2] !== 16'hBEEF || sram0[3] !== 16'hDEAD)
            $display("FAIL store_data got=%h,%h exp BEEF,DEAD", sram0[2], sram0[3]);
        else n_pass++;
        access(0, 1'b0, 1'b1, 32'h404, 32'h0, low, we_cyc, dq_err, rv);
        model_update(0, 1'b0, 32'h404, 32'h0);
        n_checks++;
        if (rv !== 32'hDEADBEEF || low !== 3)
            $display("FAIL load_back rv=%h low=%0d exp DEADBEEF/3", rv, low);
        else n_pass++;
        n_checks++;
        if (we_cyc !== 0 || dq_err !== 0)
            $display("FAIL load_bus we=%0d dq_err=%0d exp 0/0", we_cyc, dq_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int low1, low2, we_cyc, dq_err;
        logic [31:0] rv;
        access(0, 1'b1, 1'b0, 32'h400, 32'h12345678, low1, we_cyc, dq_err, rv);
        model_update(0, 1'b1, 32'h400, 32'h12345678);
        access(0, 1'b0, 1'b1, 32'h400, 32'h0, low2, we_cyc, dq_err, rv);
        model_update(0, 1'b0, 32'h400, 32'h0);
        n_checks++;
        if (low1 !== 3 || low2 !== 3 || rv !== 32'h12345678)
            $display("FAIL back_to_back low=%0d,%0d rv=%h exp 3,3,12345678", low1, low2, rv);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        r_en[0] = 1'b0; w_en[0] = 1'b1; alu[0] = 32'h40C; st[0] = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b1 || we_n[0] !== 1'b0)
            $display("FAIL reset_mid_during ready=%b we_n=%b exp 1/0", rdy[0], we_n[0]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (rdy[0] !== 1'b1 || we_n[0] !== 1'b1 || rval[0] !== 32'h0 || saddr[0] !== '0)
            $display("FAIL reset_mid_after ready=%b we_n=%b rv=%h addr=%h exp 1/1/0/0",
                     rdy[0], we_n[0], rval[0], saddr[0]);
        else n_pass++;
        rst = 1'b0; w_en[0] = 1'b0;
        // Aborted store contents are whatever reached the SRAM; reset drops model state.
        ref_mem[wa_of(32'h40C)] = {sram0[2 * wa_of(32'h40C) + 1], sram0[2 * wa_of(32'h40C)]};
        for (int d = 0; d < 2; d++) begin
            last_load[d] = '0; buf_valid[d] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_wait3();
        int low, we_cyc, dq_err, bad;
        logic [31:0] rv, v;
        logic [AW-1:0] lo;
        v = $urandom;
        access(1, 1'b1, 1'b0, 32'h500, v, low, we_cyc, dq_err, rv);
        model_update(1, 1'b1, 32'h500, v);
        n_checks++;
        if (low !== 7 || we_cyc !== 6) $display("FAIL wait3_store low=%0d we=%0d exp 7/6", low, we_cyc);
        else n_pass++;
        access(1, 1'b0, 1'b1, 32'h500, 32'h0, low, we_cyc, dq_err, rv);
        model_update(1, 1'b0, 32'h500, 32'h0);
        lo = AW'(2 * wa_of(32'h500));
        bad = 0;
        for (int i = 1; i <= 3; i++) if (addr_log[i] !== lo) bad++;
        for (int i = 4; i <= 6; i++) if (addr_log[i] !== (lo | AW'(1))) bad++;
        n_checks++;
        if (low !== 7 || bad !== 0) $display("FAIL wait3_load_timing low=%0d addr_bad=%0d exp 7/0", low, bad);
        else n_pass++;
        n_checks++;
        if (rv !== v || dq_err !== 0) $display("FAIL wait3_load_data rv=%h exp=%h dq_err=%0d", rv, v, dq_err);
        else n_pass++;
    endtask

    task automatic test_last_read_buf();
        int low, we_cyc, dq_err, el;
        logic [31:0] rv, v;
        access(0, 1'b0, 1'b1, 32'h408, 32'h0, low, we_cyc, dq_err, rv);
        model_update(0, 1'b0, 32'h408, 32'h0);
        el = exp_low(0, 1'b0, 32'h408);
        access(0, 1'b0, 1'b1, 32'h408, 32'h0, low, we_cyc, dq_err, rv);
        n_checks++;
        if (low !== el || rv !== last_load[0])
            $display("FAIL buf_repeat_load low=%0d exp=%0d rv=%h exp=%h", low, el, rv, last_load[0]);
        else n_pass++;
        model_update(0, 1'b0, 32'h408, 32'h0);
        v = $urandom;
        access(0, 1'b1, 1'b0, 32'h408, v, low, we_cyc, dq_err, rv);
        model_update(0, 1'b1, 32'h408, v);
        el = exp_low(0, 1'b0, 32'h408);
        access(0, 1'b0, 1'b1, 32'h408, 32'h0, low, we_cyc, dq_err, rv);
        model_update(0, 1'b0, 32'h408, 32'h0);
        n_checks++;
        if (low !== el || el !== 3 || rv !== v)
            $display("FAIL buf_after_store low=%0d exp=3 rv=%h exp=%h", low, rv, v);
        else n_pass++;
    endtask

    task automatic test_random();
        int low, we_cyc, dq_err, d, op, el, ew;
        logic [31:0] a, v, rv, er;
        bit is_store;
        for (int n = 0; n < 60; n++) begin
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            is_store = (op != 0);
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1023));
            else a = 32'd1024 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            v  = $urandom;
            el = exp_low(d, is_store, a);
            ew = is_store ? 2 * wait_of[d] : 0;
            access(d, op != 0, op != 1, a, v, low, we_cyc, dq_err, rv);
            model_update(d, is_store, a, v);
            er = last_load[d];
            n_checks++;
            if (low !== el || we_cyc !== ew)
                $display("FAIL rand_timing op%0d dut%0d low=%0d exp=%0d we=%0d exp=%0d", n, d, low, el, we_cyc, ew);
            else n_pass++;
            n_checks++;
            if (rv !== er || dq_err !== 0)
                $display("FAIL rand_value op%0d dut%0d addr=%h rv=%h exp=%h dq_err=%0d", n, d, a, rv, er, dq_err);
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wait_of[0] = 1;
        wait_of[1] = 3;
        for (int i = 0; i < (1 << AW); i++) begin
            sram0[i] = 16'h0;
            sram1[i] = 16'h0;
        end
        test_reset();
        test_store_load();
        test_back_to_back();
        test_reset_mid();
        test_wait3();
        test_last_read_buf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM-stage data-memory controller. Sits between the EX/MEM pipeline register and the MEM/WB register (MEM_Stage_reg).
- Turns 32-bit load/store requests into two sequential 16-bit accesses on an external asynchronous SRAM.
- Drives `ready` low to freeze the whole pipeline until the access completes.
- Its `MEM_read_value` feeds MEM_read_value_in of the MEM/WB register; `ready` inverted drives that register's freeze.

Parameters:
- ADDR_BASE, 1024: byte offset subtracted from ALU_result before addressing SRAM.
- SRAM_WAIT, 1: cycles each 16-bit phase is held; legal range 1..7.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- MEM_R_EN  input  1  load request from EX/MEM register
- MEM_W_EN  input  1  store request from EX/MEM register
- ALU_result  input  32  byte address of access
- ST_value  input  32  store data
- ready  output  1  1 = access complete or no access; 0 = freeze pipeline
- MEM_read_value  output  32  load data, registered
- SRAM_DQ  inout  16  SRAM data bus; high-Z unless writing
- SRAM_ADDR  output  SRAM_AW  SRAM halfword address
- SRAM_WE_N  output  1  SRAM write enable, active low

Behaviour:
- Synchronous, active-high reset on clk; any state, including mid-access.
- Reset values:
  - state = IDLE
  - MEM_read_value = 0
  - SRAM_WE_N = 1
  - SRAM_DQ = Z
  - SRAM_ADDR = 0
  - phase counter = 0
  - captured request cleared
- `ready` = 1 while rst is high. An aborted access is dropped, not resumed.
- Word address: `wa = (ALU_result - ADDR_BASE) >> 2`, using the 32-bit subtraction with wrap.
- Halfword addresses: low half = `{wa[SRAM_AW-2:0], 0}`, high half = `{wa[SRAM_AW-2:0], 1}`. Excess upper bits are ignored.
- Request = MEM_R_EN | MEM_W_EN. If both are set, the access is treated as a store.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE:
    - With no request, stay in IDLE; ready = 1.
    - With a request, capture wa, ST_value and the op type; ready = 0; go to LO.
  - LO: drive the low-half address for SRAM_WAIT cycles (phase counter); ready = 0; then go to HI.
  - HI: drive the high-half address for SRAM_WAIT cycles; ready = 0; then go to DONE.
  - DONE: ready = 1 for exactly one cycle; go to IDLE. The pipeline advances on this edge.
- Stall: ready is low for 1 + 2·SRAM_WAIT cycles, then high for one cycle. With SRAM_WAIT = 1 that is 3 low, then 1 high.
- `ready` is combinational from state and the request inputs. All SRAM outputs come from state and captured registers only.
- Store phases:
  - SRAM_WE_N = 0 for every cycle of LO and HI.
  - SRAM_DQ = captured ST_value[15:0] in LO and ST_value[31:16] in HI.
- Load phases:
  - SRAM_WE_N = 1 and SRAM_DQ = Z.
  - SRAM_DQ is sampled on the last cycle of LO into bits [15:0] and the last cycle of HI into bits [31:16].
  - MEM_read_value is updated on the HI→DONE edge and holds its value until the next load completes.
- In IDLE and DONE: SRAM_WE_N = 1 and SRAM_DQ = Z.
- Request inputs are ignored outside IDLE. The frozen pipeline holds them stable.
- A request present in IDLE on the cycle immediately after DONE starts a new access; no bubble is required.

Optional Feature:
- Macro: LAST_READ_BUF_EN.
- When defined: a one-entry buffer holds {valid, wa, data} of the last completed load.
  - A load in IDLE whose wa matches a valid entry skips LO/HI and goes directly to DONE: ready low 1 cycle, MEM_read_value = buffered data.
  - A store to a matching wa clears valid.
  - Reset clears valid.
- When undefined: every load performs the full SRAM access, and the buffer logic is absent.

Test Plan:
- Reset mid-access: assert rst during HI of a store → next cycle state IDLE, SRAM_WE_N = 1, DQ = Z, ready = 1, MEM_read_value = 0.
- Store, SRAM_WAIT = 1: ALU_result = 0x404, ST_value = 0xDEADBEEF.
  - SRAM writes addr 2 = 0xBEEF and addr 3 = 0xDEAD, WE_N low 2 cycles.
  - ready pattern 0,0,0,1.
- Load back: ALU_result = 0x404 → MEM_read_value = 0xDEADBEEF on the DONE cycle; DQ never driven by the DUT.
- Back-to-back: store 0x12345678 to 0x400, then load 0x400 starting the cycle after DONE → no idle gap; load returns 0x12345678.
- SRAM_WAIT = 3: a load keeps each address stable 3 cycles; ready low 7 cycles, then high 1 cycle.
- With LAST_READ_BUF_EN:
  - Load 0x408 twice → second load has ready low 1 cycle, same data.
  - Store to 0x408, then load → full 1 + 2·SRAM_WAIT stall.
